// File: rtl/mastermind_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mastermind_pkg
//  Description : Shared state encoding, parameter defaults and width helpers
//                for the Mastermind game engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package mastermind_pkg;

    // Game engine states
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WAIT_GUESS  = 3'd1,
        SCORE_EXACT = 3'd2,
        SCORE_COLOR = 3'd3,
        WRITE       = 3'd4,
        WON         = 3'd5,
        LOST        = 3'd6
    } state_t;

    localparam int DEF_NUM_PEGS  = 4;
    localparam int DEF_COLOR_W   = 3;
    localparam int DEF_MAX_TURNS = 8;

    // Width able to hold a peg count 0..pegs
    function automatic int cnt_width(input int pegs);
        return $clog2(pegs + 1);
    endfunction

    // Width able to hold a turn count 0..turns
    function automatic int turn_width(input int turns);
        return $clog2(turns + 1);
    endfunction

    // Width of a history index 0..turns-1, at least one bit
    function automatic int idx_width(input int turns);
        return (turns > 1) ? $clog2(turns) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mm_color_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mm_color_counter
//  Description : For one colour, counts its occurrences in the code and in
//                the guess and returns the smaller count.
//  Revision    : 1.0 - initial release
// ============================================================================
module mm_color_counter #(
    parameter int NUM_PEGS = 4,
    parameter int COLOR_W  = 3,
    parameter int CNT_W    = 3
) (
    input  logic [NUM_PEGS*COLOR_W-1:0] code,
    input  logic [NUM_PEGS*COLOR_W-1:0] guess,
    input  logic [COLOR_W-1:0]          color,
    output logic [CNT_W-1:0]            min_count
);

    logic [CNT_W-1:0] code_cnt;
    logic [CNT_W-1:0] guess_cnt;

    // Tally the colour in both vectors and keep the minimum
    always_comb begin
        code_cnt  = '0;
        guess_cnt = '0;
        for (int i = 0; i < NUM_PEGS; i++) begin
            if (code[i*COLOR_W +: COLOR_W] == color) begin
                code_cnt = code_cnt + CNT_W'(1);
            end
            if (guess[i*COLOR_W +: COLOR_W] == color) begin
                guess_cnt = guess_cnt + CNT_W'(1);
            end
        end
        min_count = (code_cnt < guess_cnt) ? code_cnt : guess_cnt;
    end

endmodule
`default_nettype wire

// File: rtl/mastermind_core.sv
`default_nettype none
// ============================================================================
//  Module      : mastermind_core
//  Description : Mastermind game engine. Holds the secret code and the guess
//                and feedback history, scores each guess over several cycles
//                (exact pass, then one cycle per colour), and tracks the turn
//                count and win/loss.
//                Optional MASTERMIND_DUP_REJECT_EN: a guess already played in
//                the current game is refused without consuming a turn.
//  Revision    : 1.0 - initial release
// ============================================================================
module mastermind_core
    import mastermind_pkg::*;
#(
    parameter  int NUM_PEGS  = DEF_NUM_PEGS,
    parameter  int COLOR_W   = DEF_COLOR_W,
    parameter  int MAX_TURNS = DEF_MAX_TURNS,
    localparam int CNT_W     = cnt_width(NUM_PEGS),
    localparam int TURN_W    = turn_width(MAX_TURNS),
    localparam int IDX_W     = idx_width(MAX_TURNS),
    localparam int CODE_W    = NUM_PEGS * COLOR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              new_game,
    input  logic [CODE_W-1:0] code_in,
    input  logic [CODE_W-1:0] guess_in,
    input  logic              guess_valid,
    output logic              guess_ready,
    output logic              score_valid,
    output logic [CNT_W-1:0]  last_exact,
    output logic [CNT_W-1:0]  last_partial,
    output logic [TURN_W-1:0] turn_count,
    output logic              won,
    output logic              lost,
    input  logic [IDX_W-1:0]  view_turn,
    output logic [CODE_W-1:0] view_guess,
    output logic [CNT_W-1:0]  view_exact,
    output logic [CNT_W-1:0]  view_partial,
    output logic              dup_reject
);

    state_t              state_q,        state_d;
    logic [CODE_W-1:0]   code_q,         code_d;
    logic [CODE_W-1:0]   guess_q,        guess_d;
    logic [CNT_W-1:0]    exact_q,        exact_d;
    logic [CNT_W-1:0]    acc_q,          acc_d;
    logic [COLOR_W-1:0]  color_idx_q,    color_idx_d;
    logic [TURN_W-1:0]   turn_count_q,   turn_count_d;
    logic [CNT_W-1:0]    last_exact_q,   last_exact_d;
    logic [CNT_W-1:0]    last_partial_q, last_partial_d;
    logic                score_valid_q,  score_valid_d;

    logic [CODE_W-1:0]   hist_guess_q   [MAX_TURNS];
    logic [CODE_W-1:0]   hist_guess_d   [MAX_TURNS];
    logic [CNT_W-1:0]    hist_exact_q   [MAX_TURNS];
    logic [CNT_W-1:0]    hist_exact_d   [MAX_TURNS];
    logic [CNT_W-1:0]    hist_partial_q [MAX_TURNS];
    logic [CNT_W-1:0]    hist_partial_d [MAX_TURNS];

    logic [CNT_W-1:0]    exact_now;
    logic [CNT_W-1:0]    color_min;
    logic [CNT_W-1:0]    partial_now;
    logic [TURN_W-1:0]   turn_next;
    logic [TURN_W-1:0]   view_turn_ext;

    // Single shared colour counter; the FSM steps its colour index
    mm_color_counter #(
        .NUM_PEGS (NUM_PEGS),
        .COLOR_W  (COLOR_W),
        .CNT_W    (CNT_W)
    ) u_color_counter (
        .code      (code_q),
        .guess     (guess_q),
        .color     (color_idx_q),
        .min_count (color_min)
    );

    // Count pegs matching in both colour and position
    always_comb begin
        exact_now = '0;
        for (int i = 0; i < NUM_PEGS; i++) begin
            if (guess_q[i*COLOR_W +: COLOR_W] == code_q[i*COLOR_W +: COLOR_W]) begin
                exact_now = exact_now + CNT_W'(1);
            end
        end
    end

    // The colour-match total always includes the exact pegs, so this cannot underflow
    assign partial_now = acc_q - exact_q;
    assign turn_next   = turn_count_q + TURN_W'(1);

`ifdef MASTERMIND_DUP_REJECT_EN
    logic dup_hit;
    logic dup_reject_q, dup_reject_d;

    // Compare the pending guess against every guess already stored this game
    always_comb begin
        dup_hit = 1'b0;
        for (int t = 0; t < MAX_TURNS; t++) begin
            if ((TURN_W'(t) < turn_count_q) && (hist_guess_q[t] == guess_q)) begin
                dup_hit = 1'b1;
            end
        end
    end
`endif

    // Next-state and datapath updates; new_game overrides everything
    always_comb begin
        state_d        = state_q;
        code_d         = code_q;
        guess_d        = guess_q;
        exact_d        = exact_q;
        acc_d          = acc_q;
        color_idx_d    = color_idx_q;
        turn_count_d   = turn_count_q;
        last_exact_d   = last_exact_q;
        last_partial_d = last_partial_q;
        score_valid_d  = 1'b0;
        hist_guess_d   = hist_guess_q;
        hist_exact_d   = hist_exact_q;
        hist_partial_d = hist_partial_q;
`ifdef MASTERMIND_DUP_REJECT_EN
        dup_reject_d   = 1'b0;
`endif

        if (new_game) begin
            code_d         = code_in;
            exact_d        = '0;
            acc_d          = '0;
            color_idx_d    = '0;
            turn_count_d   = '0;
            last_exact_d   = '0;
            last_partial_d = '0;
            for (int t = 0; t < MAX_TURNS; t++) begin
                hist_guess_d[t]   = '0;
                hist_exact_d[t]   = '0;
                hist_partial_d[t] = '0;
            end
            state_d = WAIT_GUESS;
        end else begin
            case (state_q)
                WAIT_GUESS: begin
                    if (guess_valid) begin
                        guess_d = guess_in;
                        state_d = SCORE_EXACT;
                    end
                end
                SCORE_EXACT: begin
                    exact_d     = exact_now;
                    acc_d       = '0;
                    color_idx_d = '0;
                    state_d     = SCORE_COLOR;
`ifdef MASTERMIND_DUP_REJECT_EN
                    if (dup_hit) begin
                        dup_reject_d = 1'b1;
                        state_d      = WAIT_GUESS;
                    end
`endif
                end
                SCORE_COLOR: begin
                    acc_d       = acc_q + color_min;
                    color_idx_d = color_idx_q + COLOR_W'(1);
                    if (color_idx_q == {COLOR_W{1'b1}}) begin
                        state_d = WRITE;
                    end
                end
                WRITE: begin
                    hist_guess_d[turn_count_q[IDX_W-1:0]]   = guess_q;
                    hist_exact_d[turn_count_q[IDX_W-1:0]]   = exact_q;
                    hist_partial_d[turn_count_q[IDX_W-1:0]] = partial_now;
                    turn_count_d   = turn_next;
                    last_exact_d   = exact_q;
                    last_partial_d = partial_now;
                    score_valid_d  = 1'b1;
                    if (exact_q == CNT_W'(NUM_PEGS)) begin
                        state_d = WON;
                    end else if (turn_next == TURN_W'(MAX_TURNS)) begin
                        state_d = LOST;
                    end else begin
                        state_d = WAIT_GUESS;
                    end
                end
                IDLE, WON, LOST: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            code_q         <= '0;
            guess_q        <= '0;
            exact_q        <= '0;
            acc_q          <= '0;
            color_idx_q    <= '0;
            turn_count_q   <= '0;
            last_exact_q   <= '0;
            last_partial_q <= '0;
            score_valid_q  <= 1'b0;
            for (int t = 0; t < MAX_TURNS; t++) begin
                hist_guess_q[t]   <= '0;
                hist_exact_q[t]   <= '0;
                hist_partial_q[t] <= '0;
            end
        end else begin
            state_q        <= state_d;
            code_q         <= code_d;
            guess_q        <= guess_d;
            exact_q        <= exact_d;
            acc_q          <= acc_d;
            color_idx_q    <= color_idx_d;
            turn_count_q   <= turn_count_d;
            last_exact_q   <= last_exact_d;
            last_partial_q <= last_partial_d;
            score_valid_q  <= score_valid_d;
            hist_guess_q   <= hist_guess_d;
            hist_exact_q   <= hist_exact_d;
            hist_partial_q <= hist_partial_d;
        end
    end

`ifdef MASTERMIND_DUP_REJECT_EN
    // Duplicate-refusal pulse register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dup_reject_q <= 1'b0;
        end else begin
            dup_reject_q <= dup_reject_d;
        end
    end

    assign dup_reject = dup_reject_q;
`else
    assign dup_reject = 1'b0;
`endif

    assign guess_ready  = (state_q == WAIT_GUESS);
    assign score_valid  = score_valid_q;
    assign last_exact   = last_exact_q;
    assign last_partial = last_partial_q;
    assign turn_count   = turn_count_q;
    assign won          = (state_q == WON);
    assign lost         = (state_q == LOST);

    assign view_turn_ext = TURN_W'(view_turn);

    // History read port: slots not yet written this game read as zero
    always_comb begin
        view_guess   = '0;
        view_exact   = '0;
        view_partial = '0;
        if (view_turn_ext < turn_count_q) begin
            view_guess   = hist_guess_q[view_turn];
            view_exact   = hist_exact_q[view_turn];
            view_partial = hist_partial_q[view_turn];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mastermind_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mastermind_core
//  Description : Directed self-checking bench for mastermind_core with the
//                default 4-peg, 3-bit, 8-turn configuration.
//                Honours MASTERMIND_DUP_REJECT_EN for the duplicate test.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mastermind_core;

    logic        clk;
    logic        reset;
    logic        new_game;
    logic [11:0] code_in;
    logic [11:0] guess_in;
    logic        guess_valid;
    logic        guess_ready;
    logic        score_valid;
    logic [2:0]  last_exact;
    logic [2:0]  last_partial;
    logic [3:0]  turn_count;
    logic        won;
    logic        lost;
    logic [2:0]  view_turn;
    logic [11:0] view_guess;
    logic [2:0]  view_exact;
    logic [2:0]  view_partial;
    logic        dup_reject;

    int errors = 0;
    int checks = 0;
    int sv_count = 0;

    mastermind_core dut (
        .clk          (clk),
        .reset        (reset),
        .new_game     (new_game),
        .code_in      (code_in),
        .guess_in     (guess_in),
        .guess_valid  (guess_valid),
        .guess_ready  (guess_ready),
        .score_valid  (score_valid),
        .last_exact   (last_exact),
        .last_partial (last_partial),
        .turn_count   (turn_count),
        .won          (won),
        .lost         (lost),
        .view_turn    (view_turn),
        .view_guess   (view_guess),
        .view_exact   (view_exact),
        .view_partial (view_partial),
        .dup_reject   (dup_reject)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count score_valid pulses seen at each active edge
    always @(posedge clk) begin
        if (score_valid) sv_count++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] pk(input logic [2:0] p0, input logic [2:0] p1,
                                       input logic [2:0] p2, input logic [2:0] p3);
        return {p3, p2, p1, p0};
    endfunction

    task automatic start_game(input logic [11:0] code);
        @(negedge clk);
        code_in  = code;
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
    endtask

    // Offer a guess, then wait (bounded) for score_valid; lat = edges after E0, -1 on timeout
    task automatic submit(input logic [11:0] g, output int lat);
        @(negedge clk);
        guess_in    = g;
        guess_valid = 1'b1;
        @(posedge clk);
        #1 guess_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (score_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) @(posedge clk);
        #1;
    endtask

    int lat;
    int sv_before;
    logic [2:0] ex_e, ex_p;

    initial begin
        reset       = 1'b1;
        new_game    = 1'b0;
        code_in     = '0;
        guess_in    = '0;
        guess_valid = 1'b0;
        view_turn   = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", guess_ready, 0);
        check("rst_score_valid", score_valid, 0);
        check("rst_turn", turn_count, 0);
        check("rst_won_lost", {won, lost}, 0);
        check("rst_last", {last_exact, last_partial}, 0);
        check("rst_view", {view_guess, view_exact, view_partial}, 0);
        @(negedge clk);
        reset = 1'b0;

        // A guess offered in IDLE is ignored
        @(negedge clk);
        guess_in    = pk(3'd1, 3'd2, 3'd3, 3'd4);
        guess_valid = 1'b1;
        @(negedge clk);
        guess_valid = 1'b0;
        sv_before = sv_count;
        idle_cycles(14);
        check("idle_no_score", sv_count - sv_before, 0);
        check("idle_ready", guess_ready, 0);

        // Winning first guess: score at E10
        start_game(pk(3'd1, 3'd2, 3'd3, 3'd4));
        #1 check("ng_ready", guess_ready, 1);
        submit(pk(3'd1, 3'd2, 3'd3, 3'd4), lat);
        check("win_latency", lat, 10);
        check("win_exact", last_exact, 4);
        check("win_partial", last_partial, 0);
        check("win_won", won, 1);
        check("win_lost", lost, 0);
        check("win_turn", turn_count, 1);
        check("win_ready", guess_ready, 0);
        idle_cycles(1);
        check("win_pulse_end", score_valid, 0);
        check("win_sticky", won, 1);

        // All colours right, all positions wrong
        start_game(pk(3'd1, 3'd2, 3'd3, 3'd4));
        #1 check("ng_clears_won", won, 0);
        check("ng_clears_turn", turn_count, 0);
        submit(pk(3'd4, 3'd3, 3'd2, 3'd1), lat);
        check("rev_latency", lat, 10);
        check("rev_exact", last_exact, 0);
        check("rev_partial", last_partial, 4);
        check("rev_ready", guess_ready, 1);
        view_turn = 3'd0;
        #1;
        check("rev_view_guess", view_guess, pk(3'd4, 3'd3, 3'd2, 3'd1));
        check("rev_view_fb", {view_exact, view_partial}, {3'd0, 3'd4});
        view_turn = 3'd1;
        #1;
        check("rev_view_unwritten", {view_guess, view_exact, view_partial}, 0);
        view_turn = 3'd0;

        // Repeated colours in code and guess
        start_game(pk(3'd1, 3'd2, 3'd1, 3'd3));
        submit(pk(3'd1, 3'd1, 3'd2, 3'd2), lat);
        check("rep1_exact", last_exact, 1);
        check("rep1_partial", last_partial, 2);

        start_game(pk(3'd1, 3'd2, 3'd3, 3'd4));
        submit(pk(3'd1, 3'd1, 3'd2, 3'd2), lat);
        check("rep2_exact", last_exact, 1);
        check("rep2_partial", last_partial, 1);

        // Eight distinct losing guesses {5,6,7,t}
        start_game(pk(3'd1, 3'd2, 3'd3, 3'd4));
        for (int t = 0; t < 8; t++) begin
            submit(pk(3'd5, 3'd6, 3'd7, 3'(t)), lat);
            ex_e = (t == 4) ? 3'd1 : 3'd0;
            ex_p = (t >= 1 && t <= 3) ? 3'd1 : 3'd0;
            check($sformatf("lose%0d_latency", t), lat, 10);
            check($sformatf("lose%0d_fb", t), {last_exact, last_partial}, {ex_e, ex_p});
            check($sformatf("lose%0d_turn", t), turn_count, t + 1);
            check($sformatf("lose%0d_lost", t), lost, (t == 7) ? 1 : 0);
        end
        check("lose_won", won, 0);
        check("lose_ready", guess_ready, 0);
        view_turn = 3'd7;
        #1;
        check("lose_view7", {view_guess, view_exact, view_partial},
              {pk(3'd5, 3'd6, 3'd7, 3'd7), 3'd0, 3'd0});
        view_turn = 3'd0;
        @(negedge clk);
        guess_in    = pk(3'd1, 3'd2, 3'd3, 3'd4);
        guess_valid = 1'b1;
        @(negedge clk);
        guess_valid = 1'b0;
        sv_before = sv_count;
        idle_cycles(14);
        check("lost_ignore_score", sv_count - sv_before, 0);
        check("lost_ignore_turn", turn_count, 8);
        check("lost_sticky", lost, 1);

        // new_game at E5 aborts an in-flight guess
        start_game(pk(3'd1, 3'd2, 3'd3, 3'd4));
        submit(pk(3'd5, 3'd5, 3'd5, 3'd5), lat);
        check("abort_pre_turn", turn_count, 1);
        @(negedge clk);
        guess_in    = pk(3'd6, 3'd6, 3'd6, 3'd6);
        guess_valid = 1'b1;
        @(posedge clk);                        // E0
        #1 guess_valid = 1'b0;
        sv_before = sv_count;
        @(posedge clk);                        // E1
        #1 check("abort_busy", guess_ready, 0);
        repeat (3) @(posedge clk);             // E2..E4
        @(negedge clk);
        new_game = 1'b1;
        @(posedge clk);                        // E5
        #1;
        check("abort_turn", turn_count, 0);
        check("abort_ready", guess_ready, 1);
        @(negedge clk);
        new_game = 1'b0;
        idle_cycles(12);
        check("abort_no_score", sv_count - sv_before, 0);

        // Same losing guess played twice
        start_game(pk(3'd1, 3'd2, 3'd3, 3'd4));
        submit(pk(3'd5, 3'd5, 3'd5, 3'd5), lat);
        check("dup_first_turn", turn_count, 1);
`ifdef MASTERMIND_DUP_REJECT_EN
        @(negedge clk);
        guess_in    = pk(3'd5, 3'd5, 3'd5, 3'd5);
        guess_valid = 1'b1;
        @(posedge clk);                        // E0
        #1 guess_valid = 1'b0;
        sv_before = sv_count;
        check("dup_e0_quiet", dup_reject, 0);
        @(posedge clk);                        // E1
        #1 check("dup_pulse", dup_reject, 1);
        check("dup_ready", guess_ready, 1);
        idle_cycles(1);
        check("dup_pulse_end", dup_reject, 0);
        idle_cycles(12);
        check("dup_no_score", sv_count - sv_before, 0);
        check("dup_turn", turn_count, 1);
`else
        submit(pk(3'd5, 3'd5, 3'd5, 3'd5), lat);
        check("dup_latency", lat, 10);
        check("dup_turn", turn_count, 2);
        check("dup_flag", dup_reject, 0);
        view_turn = 3'd1;
        #1 check("dup_view1", {view_guess, view_exact, view_partial},
                 {pk(3'd5, 3'd5, 3'd5, 3'd5), 3'd0, 3'd0});
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
